// File: rtl/dft4_stream.sv
// Streaming 4-point DFT: load four complex samples, compute in one cycle, drain four bins.
// Define DFT4_SCALE_EN for a 1/4-normalised output (floor shift by 2).
module dft4_stream #(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W+1:0] out_re,
   output logic signed [DATA_W+1:0] out_im,
   output logic [1:0]               out_idx,
   output logic                     out_last,
   output logic                     busy
);

   localparam int OUT_W = DATA_W + 2;

   typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;
   typedef logic signed [OUT_W-1:0] word_t;

   state_t     state;
   logic [1:0] cnt;
   logic [1:0] kidx;
   word_t      xr [4];
   word_t      xi [4];
   word_t      br [4];
   word_t      bi [4];

   word_t e0r, e0i, e1r, e1i, o0r, o0i, o1r, o1i;

   function automatic word_t sc(input word_t v);
`ifdef DFT4_SCALE_EN
      return v >>> 2;
`else
      return v;
`endif
   endfunction

   always_comb begin
      e0r = xr[0] + xr[2];
      e0i = xi[0] + xi[2];
      e1r = xr[0] - xr[2];
      e1i = xi[0] - xi[2];
      o0r = xr[1] + xr[3];
      o0i = xi[1] + xi[3];
      o1r = xr[1] - xr[3];
      o1i = xi[1] - xi[3];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         cnt   <= '0;
         kidx  <= '0;
         for (int i = 0; i < 4; i++) begin
            xr[i] <= '0;
            xi[i] <= '0;
            br[i] <= '0;
            bi[i] <= '0;
         end
      end else begin
         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  xr[cnt] <= word_t'(in_re);
                  xi[cnt] <= word_t'(in_im);
                  cnt     <= cnt + 2'd1;
                  if (cnt == 2'd3) state <= CALC;
               end
            end
            CALC: begin
               // X1 = E1 - j*O1, X3 = E1 + j*O1
               br[0] <= sc(e0r + o0r);
               bi[0] <= sc(e0i + o0i);
               br[1] <= sc(e1r + o1i);
               bi[1] <= sc(e1i - o1r);
               br[2] <= sc(e0r - o0r);
               bi[2] <= sc(e0i - o0i);
               br[3] <= sc(e1r - o1i);
               bi[3] <= sc(e1i + o1r);
               kidx  <= '0;
               state <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  kidx <= kidx + 2'd1;
                  if (kidx == 2'd3) state <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == DRAIN);
   assign out_re    = br[kidx];
   assign out_im    = bi[kidx];
   assign out_idx   = kidx;
   assign out_last  = out_valid && (kidx == 2'd3);
   assign busy      = !((state == LOAD) && (cnt == 2'd0));

endmodule

// File: tb/tb_dft4_stream.sv
// Directed-vector bench for dft4_stream (DATA_W=8).
// Honours DFT4_SCALE_EN for the expected bin values.
module tb_dft4_stream;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] in_re = '0;
   logic signed [7:0] in_im = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic signed [9:0] out_re;
   logic signed [9:0] out_im;
   logic [1:0]        out_idx;
   logic              out_last;
   logic              busy;

   int nvec = 0;
   int nerr = 0;

   dft4_stream #(.DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic int sc(input int v);
`ifdef DFT4_SCALE_EN
      return v >>> 2;
`else
      return v;
`endif
   endfunction

   task automatic push4(input int r[4], input int i[4]);
      for (int n = 0; n < 4; n++) begin
         int t = 0;
         in_valid = 1'b1;
         in_re = 8'(r[n]);
         in_im = 8'(i[n]);
         while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
         end
         if (!in_ready) chk("in_wait", 0, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic recv(input int er[4], input int ei[4],
                       input int stall_k, input int nb);
      for (int k = 0; k < nb; k++) begin
         int t = 0;
         out_ready = 1'b1;
         while (!out_valid && t < 50) begin
            @(posedge clk); #1; t++;
         end
         if (!out_valid) chk("out_wait", 0, 1);
         if (k == stall_k) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_re = 8'sd55;
            for (int s = 0; s < 3; s++) begin
               @(posedge clk); #1;
               chk("stall_re", out_re, sc(er[k]));
               chk("stall_im", out_im, sc(ei[k]));
               chk("stall_idx", out_idx, k);
               chk("stall_vld", out_valid, 1);
               chk("stall_rdy", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
         end
         chk($sformatf("re%0d", k), out_re, sc(er[k]));
         chk($sformatf("im%0d", k), out_im, sc(ei[k]));
         chk($sformatf("idx%0d", k), out_idx, k);
         chk($sformatf("last%0d", k), out_last, (k == 3) ? 1 : 0);
         if (k < 3) chk("in_rdy_drain", in_ready, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int nin, nout, nlow, run, firstrun;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
      chk("rst_out_idx", out_idx, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // impulse, with latency check
      push4('{1, 0, 0, 0}, '{0, 0, 0, 0});
      chk("calc_valid", out_valid, 0);
      chk("calc_ready", in_ready, 0);
      chk("calc_busy", busy, 1);
      @(posedge clk); #1;
      chk("lat_valid", out_valid, 1);
      recv('{1, 1, 1, 1}, '{0, 0, 0, 0}, -1, 4);
      chk("post_ready", in_ready, 1);
      chk("post_valid", out_valid, 0);
      chk("post_busy", busy, 0);

      // shifted impulse
      push4('{0, 1, 0, 0}, '{0, 0, 0, 0});
      recv('{1, 0, -1, 0}, '{0, -1, 0, 1}, -1, 4);

      // extremes
      push4('{-128, -128, -128, -128}, '{-128, -128, -128, -128});
      recv('{-512, 0, 0, 0}, '{-512, 0, 0, 0}, -1, 4);

      // general vector with back-pressure on bin 1
      push4('{1, 3, 5, 7}, '{2, 4, 6, 8});
      recv('{16, -8, -4, 0}, '{20, 0, -4, -8}, 1, 4);
      chk("bp_ready", in_ready, 1);

      // reset mid-drain after bin 1
      push4('{9, 9, 9, 9}, '{3, 3, 3, 3});
      recv('{36, 0, 0, 0}, '{12, 0, 0, 0}, -1, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_re", out_re, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      push4('{2, 2, 2, 2}, '{0, 0, 0, 0});
      recv('{8, 0, 0, 0}, '{0, 0, 0, 0}, -1, 4);

      // back-to-back frames, in_valid held high
      nin = 0; nout = 0; nlow = 0; run = 0; firstrun = -1;
      in_valid = 1'b1;
      in_re = 8'sd1;
      in_im = 8'sd0;
      out_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (in_valid && in_ready) nin++;
         if (out_valid && out_ready) nout++;
         if (!in_ready) begin
            nlow++;
            run++;
         end else if (run > 0) begin
            if (firstrun < 0) firstrun = run;
            run = 0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("b2b_in", nin, 8);
      chk("b2b_out", nout, 8);
      chk("b2b_low", nlow, 10);
      chk("b2b_gap", firstrun, 5);
      chk("b2b_end_ready", in_ready, 1);
      chk("b2b_end_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
